// File: rtl/ram_readahead_ctrl.sv
// Two-requester arbiter and sequencer for a two-bank read-ahead RAM path.
// Each grant fetches the requested half-line plus its neighbour unless tagged.
module ram_readahead_ctrl #(
    parameter int PRIO_FIXED = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [20:0] addr0,
    output logic [7:0]  data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [20:0] addr1,
    output logic [7:0]  data1,
    output logic        ack1,
    input  logic        inval,
    output logic        bank0_rd,
    output logic [20:0] bank0_addr,
    input  logic [7:0]  bank0_data,
    input  logic        bank0_ready,
    output logic        bank1_rd,
    output logic [20:0] bank1_addr,
    input  logic [7:0]  bank1_data,
    input  logic        bank1_ready,
    output logic [15:0] hit_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t      state, state_nx;
    logic        gnt, last, inv_seen, pick;
    logic [20:0] addr_q, tag0, tag1, fa0, fa1;
    logic        valid0, valid1, need0, need1, go, hit, enter_ack;
    logic [7:0]  rdata;

    assign fa0 = {addr_q[20:4] + 17'(addr_q[3]), 1'b0, addr_q[2:0]};
    assign fa1 = {addr_q[20:4], 1'b1, addr_q[2:0]};

    assign need0 = !valid0 || (tag0 != fa0);
    assign need1 = !valid1 || (tag1 != fa1);
    assign hit   = !need0 && !need1;
    assign go    = (!need0 || bank0_ready) && (!need1 || bank1_ready);

    // Simultaneous requests favour whoever was not served last.
    assign pick = (req0 && req1) ? ((PRIO_FIXED != 0) ? 1'b0 : ~last) : req1;

    assign rdata     = addr_q[3] ? bank1_data : bank0_data;
    assign enter_ack = (state != ACK) && (state_nx == ACK);

    assign ack0 = (state == ACK) && !gnt;
    assign ack1 = (state == ACK) && gnt;

    // The tag register doubles as the held fetch address.
    assign bank0_addr = bank0_rd ? fa0 : tag0;
    assign bank1_addr = bank1_rd ? fa1 : tag1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        bank0_rd = 1'b0;
        bank1_rd = 1'b0;
        unique case (state)
            IDLE: if (req0 || req1) state_nx = ISSUE;
            ISSUE: begin
                if (hit) begin
                    state_nx = ACK;
                end else if (go) begin
                    bank0_rd = need0;
                    bank1_rd = need1;
                    state_nx = WAIT;
                end
            end
            WAIT: if (bank0_ready && bank1_ready) state_nx = ACK;
            ACK:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= 1'b0;
            last     <= 1'b1;
            inv_seen <= 1'b0;
            addr_q   <= '0;
            tag0     <= '0;
            tag1     <= '0;
            valid0   <= 1'b0;
            valid1   <= 1'b0;
            data0    <= '0;
            data1    <= '0;
            hit_cnt  <= '0;
        end else begin
            if (state == IDLE && (req0 || req1)) begin
                gnt      <= pick;
                addr_q   <= pick ? addr1 : addr0;
                inv_seen <= inval;
            end else if (inval) begin
                inv_seen <= 1'b1;
            end
            if (bank0_rd) tag0 <= fa0;
            if (bank1_rd) tag1 <= fa1;
            if (enter_ack) begin
                if (gnt) data1 <= rdata;
                else     data0 <= rdata;
                if (!inv_seen && !inval) begin
                    valid0 <= 1'b1;
                    valid1 <= 1'b1;
                end
                if (state == ISSUE && hit_cnt != 16'hFFFF)
                    hit_cnt <= hit_cnt + 16'd1;
            end
            if (inval) begin
                valid0 <= 1'b0;
                valid1 <= 1'b0;
            end
            if (state == ACK) last <= gnt;
        end
    end

endmodule

// File: tb/tb_ram_readahead_ctrl.sv
// Directed bench for ram_readahead_ctrl: hits, misses, arbitration,
// line wrap, invalidation and mid-transaction reset.
module tb_ram_readahead_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, inval = 1'b0;
    logic [20:0] addr0 = '0, addr1 = '0;
    logic [7:0]  data0, data1;
    logic        ack0, ack1;
    logic        bank0_rd, bank1_rd;
    logic [20:0] bank0_addr, bank1_addr;
    logic [7:0]  b0_data = '0, b1_data = '0;
    logic        b0_ready = 1'b1, b1_ready = 1'b1;
    logic [15:0] hit_cnt;

    logic        f_req0 = 1'b0, f_req1 = 1'b0;
    logic [7:0]  f_data0, f_data1;
    logic        f_ack0, f_ack1, f_rd0, f_rd1;
    logic [20:0] f_baddr0, f_baddr1;
    logic [15:0] f_hit;

    int total = 0, passed = 0, failed = 0;
    int lat_b0 = 1, lat_b1 = 1;
    int cnt0 = 0, cnt1 = 0;
    int rdn0 = 0, rdn1 = 0, busy_rd = 0;
    int fa0n = 0, fa1n = 0;
    logic [20:0] ba0 = '0, ba1 = '0;

    always #5 clk = ~clk;

    ram_readahead_ctrl #(.PRIO_FIXED(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
        .inval(inval),
        .bank0_rd(bank0_rd), .bank0_addr(bank0_addr),
        .bank0_data(b0_data), .bank0_ready(b0_ready),
        .bank1_rd(bank1_rd), .bank1_addr(bank1_addr),
        .bank1_data(b1_data), .bank1_ready(b1_ready),
        .hit_cnt(hit_cnt)
    );

    ram_readahead_ctrl #(.PRIO_FIXED(1)) dut_fix (
        .clk(clk), .rst_n(rst_n),
        .req0(f_req0), .addr0(21'h0), .data0(f_data0), .ack0(f_ack0),
        .req1(f_req1), .addr1(21'h0), .data1(f_data1), .ack1(f_ack1),
        .inval(1'b0),
        .bank0_rd(f_rd0), .bank0_addr(f_baddr0),
        .bank0_data(8'hA5), .bank0_ready(1'b1),
        .bank1_rd(f_rd1), .bank1_addr(f_baddr1),
        .bank1_data(8'h5A), .bank1_ready(1'b1),
        .hit_cnt(f_hit)
    );

    // Bank models: ready drops on the sampling edge, data = addr byte ^ key.
    always @(posedge clk) begin
        if (bank0_rd) rdn0 <= rdn0 + 1;
        if (bank0_rd && !b0_ready) busy_rd <= busy_rd + 1;
        if (bank0_rd && b0_ready) begin
            b0_ready <= 1'b0;
            cnt0 <= lat_b0;
            ba0 <= bank0_addr;
        end else if (!b0_ready) begin
            if (cnt0 <= 1) begin
                b0_ready <= 1'b1;
                b0_data <= ba0[7:0] ^ 8'h11;
            end else cnt0 <= cnt0 - 1;
        end
    end

    always @(posedge clk) begin
        if (bank1_rd) rdn1 <= rdn1 + 1;
        if (bank1_rd && !b1_ready) busy_rd <= busy_rd + 1;
        if (bank1_rd && b1_ready) begin
            b1_ready <= 1'b0;
            cnt1 <= lat_b1;
            ba1 <= bank1_addr;
        end else if (!b1_ready) begin
            if (cnt1 <= 1) begin
                b1_ready <= 1'b1;
                b1_data <= ba1[7:0] ^ 8'h22;
            end else cnt1 <= cnt1 - 1;
        end
    end

    always @(posedge clk) begin
        if (f_ack0) fa0n <= fa0n + 1;
        if (f_ack1) fa1n <= fa1n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [20:0] a, input int inv_at,
                           output int lat, output logic [7:0] d);
        bit done;
        done = 0;
        @(negedge clk);
        req0 = 1'b1;
        addr0 = a;
        lat = 0;
        d = '0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            inval = (lat == inv_at);
            if (ack0) begin
                done = 1;
                d = data0;
            end
        end
        inval = 1'b0;
        req0 = 1'b0;
        if (!done) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        chk("ack_one_cycle", {31'd0, ack0}, 32'd0);
    endtask

    int lat, r0, r1;
    logic [7:0] d;
    int seq[$];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_rd", {30'd0, bank0_rd, bank1_rd}, 32'd0);
        chk("rst_hit", {16'd0, hit_cnt}, 32'd0);
        chk("rst_baddr", {11'd0, bank0_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        r0 = rdn0; r1 = rdn1;
        request(21'h00018, 0, lat, d);
        chk("miss_lat", lat, 4);
        chk("miss_data", {24'd0, d}, 32'h3A);
        chk("miss_b0addr", {11'd0, bank0_addr}, 32'h20);
        chk("miss_b1addr", {11'd0, bank1_addr}, 32'h18);
        chk("miss_rd0", rdn0 - r0, 1);
        chk("miss_rd1", rdn1 - r1, 1);
        chk("miss_hit", {16'd0, hit_cnt}, 0);

        r0 = rdn0; r1 = rdn1;
        request(21'h00018, 0, lat, d);
        chk("hit1_lat", lat, 2);
        chk("hit1_data", {24'd0, d}, 32'h3A);
        request(21'h00018, 0, lat, d);
        chk("hit2_lat", lat, 2);
        chk("hit_no_rd", (rdn0 - r0) + (rdn1 - r1), 0);
        chk("hit_cnt2", {16'd0, hit_cnt}, 2);

        r0 = rdn0; r1 = rdn1;
        request(21'h00010, 0, lat, d);
        chk("part_lat", lat, 4);
        chk("part_data", {24'd0, d}, 32'h01);
        chk("part_rd0", rdn0 - r0, 1);
        chk("part_rd1", rdn1 - r1, 0);

        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 21'h00010; addr1 = 21'h00010;
        for (int i = 0; i < 40 && seq.size() < 4; i++) begin
            @(posedge clk);
            #1;
            if (ack0) begin
                seq.push_back(0);
                chk("rr_data0", {24'd0, data0}, 32'h01);
            end
            if (ack1) begin
                seq.push_back(1);
                chk("rr_data1", {24'd0, data1}, 32'h01);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_count", seq.size(), 4);
        while (seq.size() < 4) seq.push_back(9);
        chk("rr_g0", seq[0], 1);
        chk("rr_g1", seq[1], 0);
        chk("rr_g2", seq[2], 1);
        chk("rr_g3", seq[3], 0);
        @(posedge clk);
        #1;
        chk("rr_hit", {16'd0, hit_cnt}, 6);

        @(negedge clk);
        f_req0 = 1'b1; f_req1 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("fix_r1_starved", fa1n, 0);
        chk("fix_r0_served", {31'd0, fa0n >= 5}, 1);
        chk("fix_data0", {24'd0, f_data0}, 32'hA5);
        f_req0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        f_req1 = 1'b0;
        chk("fix_r1_after", {31'd0, fa1n > 0}, 1);

        r0 = rdn0; r1 = rdn1;
        request(21'h1FFFF8, 0, lat, d);
        chk("wrap_lat", lat, 4);
        chk("wrap_data", {24'd0, d}, 32'hDA);
        chk("wrap_b0addr", {11'd0, bank0_addr}, 32'h0);
        chk("wrap_b1addr", {11'd0, bank1_addr}, 32'h1FFFF8);
        chk("wrap_rd", (rdn0 - r0) + (rdn1 - r1), 2);

        lat_b0 = 3; lat_b1 = 3;
        request(21'h00018, 2, lat, d);
        chk("inv_lat", lat, 6);
        chk("inv_data", {24'd0, d}, 32'h3A);
        lat_b0 = 1; lat_b1 = 1;
        r0 = rdn0; r1 = rdn1;
        request(21'h00018, 0, lat, d);
        chk("inv_refetch", (rdn0 - r0) * 10 + (rdn1 - r1), 11);
        chk("inv_ref_data", {24'd0, d}, 32'h3A);
        chk("inv_hit", {16'd0, hit_cnt}, 6);

        lat_b0 = 3; lat_b1 = 3;
        @(negedge clk);
        req0 = 1'b1;
        addr0 = 21'h00010;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rstw_no_ack", {31'd0, ack0}, 32'd0);
        end
        chk("rstw_hit", {16'd0, hit_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        lat_b0 = 1; lat_b1 = 1;
        r0 = rdn0; r1 = rdn1;
        request(21'h00010, 0, lat, d);
        chk("rstw_refetch", (rdn0 - r0) * 10 + (rdn1 - r1), 11);
        chk("rstw_data", {24'd0, d}, 32'h01);
        chk("rstw_hit_after", {16'd0, hit_cnt}, 0);
        chk("proto_busy_rd", busy_rd, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
